mis_stimulus_gen: RTL and testbench

//  Drive-side counterpart of the NOR/inverter delay chain: generates the two chain inputs
//  (myinA1, myinA2) as a multi-input-switching (MIS) event with programmable skew, then

---
 rtl/mis_stimulus_gen_if.sv | 27 ++
 rtl/mis_stimulus_gen.sv | 157 +++++++++++++++
 tb/tb_mis_stimulus_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mis_stimulus_gen_if.sv
// Control/result bus between the measurement controller and the MIS stimulus generator.
interface mis_stimulus_gen_if #(
  parameter int DELTA_W  = 8,
  parameter int SETTLE_W = 8,
  parameter int CNT_W    = 16
);
  logic                       start;
  logic                       dir;
  logic signed [DELTA_W-1:0]  delta;
  logic [SETTLE_W-1:0]        settle;
  logic                       busy;
  logic                       done;
  logic [CNT_W-1:0]           meas_cycles;
  logic                       timed_out;

  // Controller side: issues requests, reads results.
  modport master (
    output start, dir, delta, settle,
    input  busy, done, meas_cycles, timed_out
  );

  // Generator side: accepts requests, reports results.
  modport slave (
    input  start, dir, delta, settle,
    output busy, done, meas_cycles, timed_out
  );
endinterface

// File: rtl/mis_stimulus_gen.sv
// Multi-input-switching stimulus generator: launches A1/A2 with a programmable skew
// and times the resulting transition on the asynchronous chain output.
module mis_stimulus_gen #(
  parameter int DELTA_W  = 8,
  parameter int SETTLE_W = 8,
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  mis_stimulus_gen_if.slave ctrl,
  output logic              myinA1,
  output logic              myinA2,
  input  logic              myout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LEAD,
    S_SKEW,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t              state;
  logic                sync1;
  logic                out_s;
  logic                ref_lvl;
  logic                dir_q;
  logic [DELTA_W-1:0]  delta_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cap_cnt;
  logic                hit;

  logic [DELTA_W-1:0]  mag;
  logic [CNT_W-1:0]    cnt_inc;
  logic                changed;
  logic                trail_now;

  // Two-flop synchronizer bringing the asynchronous chain output into the clk domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      out_s <= 1'b0;
    end else begin
      sync1 <= myout;
      out_s <= sync1;
    end
  end

  // Skew magnitude, saturating counter step, change and trailing-edge detection.
  always_comb begin
    // NOTE: every signal gets a value on every path, so no latch is inferred.
    mag       = delta_q[DELTA_W-1] ? ((~delta_q) + DELTA_W'(1)) : delta_q;
    cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    changed   = (out_s != ref_lvl);
    trail_now = (cnt == CNT_W'(mag));
  end

  // Measurement sequencer with registered chain inputs and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments everywhere here, so every flop sees pre-edge values.
    if (!rst_n) begin
      state            <= S_IDLE;
      myinA1           <= 1'b0;
      myinA2           <= 1'b0;
      ctrl.busy        <= 1'b0;
      ctrl.done        <= 1'b0;
      ctrl.meas_cycles <= '0;
      ctrl.timed_out   <= 1'b0;
      ref_lvl          <= 1'b0;
      dir_q            <= 1'b0;
      delta_q          <= '0;
      settle_cnt       <= '0;
      cnt              <= '0;
      cap_cnt          <= '0;
      hit              <= 1'b0;
    end else begin
      ctrl.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctrl.start) begin
            dir_q          <= ctrl.dir;
            delta_q        <= ctrl.delta;
            settle_cnt     <= ctrl.settle;
            myinA1         <= ~ctrl.dir;
            myinA2         <= ~ctrl.dir;
            ctrl.busy      <= 1'b1;
            ctrl.timed_out <= 1'b0;
            hit            <= 1'b0;
            state          <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            // Launch edge: reference level taken, leading input(s) switch, counter starts at 1.
            ref_lvl <= out_s;
            cnt     <= CNT_W'(1);
            if (delta_q == '0) begin
              myinA1 <= dir_q;
              myinA2 <= dir_q;
            end else if (!delta_q[DELTA_W-1]) begin
              myinA1 <= dir_q;
            end else begin
              myinA2 <= dir_q;
            end
            state <= S_LEAD;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_W'(1);
          end
        end
        S_LEAD, S_SKEW: begin
          cnt <= cnt_inc;
          // An early response is captured, but the trailing edge is still completed.
          if (changed && !hit) begin
            hit     <= 1'b1;
            cap_cnt <= cnt;
          end
          if (delta_q == '0 || trail_now) begin
            myinA1 <= dir_q;
            myinA2 <= dir_q;
            state  <= S_WAIT;
          end else begin
            state <= S_SKEW;
          end
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (hit || changed) begin
            ctrl.meas_cycles <= hit ? cap_cnt : cnt;
            ctrl.timed_out   <= 1'b0;
            ctrl.done        <= 1'b1;
            ctrl.busy        <= 1'b0;
            state            <= S_DONE;
          end else if (cnt >= TIMEOUT_C) begin
            ctrl.meas_cycles <= TIMEOUT_C;
            ctrl.timed_out   <= 1'b1;
            ctrl.done        <= 1'b1;
            ctrl.busy        <= 1'b0;
            state            <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mis_stimulus_gen.sv
// Directed bench for mis_stimulus_gen: launch timing, skew, measured latency, timeout, reset abort.
module tb_mis_stimulus_gen;
  localparam int DELTA_W  = 8;
  localparam int SETTLE_W = 8;
  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic myout = 1'b1;
  logic myinA1;
  logic myinA2;

  int n_vec  = 0;
  int n_miss = 0;

  mis_stimulus_gen_if #(.DELTA_W(DELTA_W), .SETTLE_W(SETTLE_W), .CNT_W(CNT_W)) bus ();

  mis_stimulus_gen #(
    .DELTA_W (DELTA_W),
    .SETTLE_W(SETTLE_W),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus),
    .myinA1(myinA1),
    .myinA2(myinA2),
    .myout (myout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One measurement: resp = negedges after the leading edge at which myout toggles (-1: never).
  task automatic run(input string tag, input logic d, input int dl, input int st,
                     input int resp, input int exp_meas, input logic exp_to, input bit poke);
    int   n;
    int   k;
    int   trail_k;
    int   done_k;
    int   mag;
    logic nd;
    logic lead_a1;
    logic lead_a2;
    nd  = ~d;
    mag = (dl < 0) ? -dl : dl;

    @(negedge clk);
    bus.start  = 1'b1;
    bus.dir    = d;
    bus.delta  = DELTA_W'(dl);
    bus.settle = SETTLE_W'(st);
    @(negedge clk);
    // Scramble the config after acceptance; the generator must use the latched copy.
    bus.start  = 1'b0;
    bus.dir    = nd;
    bus.delta  = '0;
    bus.settle = '0;
    check({tag, "/busy_on"}, bus.busy, 1);
    check({tag, "/a1_init"}, myinA1, nd);
    check({tag, "/a2_init"}, myinA2, nd);
    check({tag, "/to_clr"}, bus.timed_out, 0);

    n = 0;
    while (myinA1 != d && myinA2 != d && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/settle_hold"}, n, st + 1);
    lead_a1 = (myinA1 == d);
    lead_a2 = (myinA2 == d);
    check({tag, "/lead_a1"}, lead_a1, (dl >= 0));
    check({tag, "/lead_a2"}, lead_a2, (dl <= 0));

    k       = 0;
    trail_k = (myinA1 == d && myinA2 == d) ? 0 : -1;
    done_k  = -1;
    while (done_k < 0 && k < 1200) begin
      @(negedge clk);
      k++;
      if (resp > 0 && k == resp - 1) myout = ~myout;
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.dir   = nd;
      end
      if (poke && k == 4) bus.start = 1'b0;
      if (trail_k < 0 && myinA1 == d && myinA2 == d) trail_k = k;
      if (bus.done) begin
        done_k = k;
        check({tag, "/meas"}, bus.meas_cycles, exp_meas);
        check({tag, "/timed_out"}, bus.timed_out, exp_to);
        check({tag, "/busy_at_done"}, bus.busy, 0);
        check({tag, "/a1_final"}, myinA1, d);
        check({tag, "/a2_final"}, myinA2, d);
      end
    end
    check({tag, "/done_seen"}, (done_k >= 0), 1);
    check({tag, "/trail_skew"}, trail_k, mag);
    check({tag, "/done_after_trail"}, (done_k > trail_k), 1);

    @(negedge clk);
    check({tag, "/done_pulse"}, bus.done, 0);
    @(negedge clk);
    check({tag, "/idle_busy"}, bus.busy, 0);
    check({tag, "/meas_hold"}, bus.meas_cycles, exp_meas);
  endtask

  initial begin
    int n;
    int n_done;
    bus.start  = 1'b0;
    bus.dir    = 1'b0;
    bus.delta  = '0;
    bus.settle = '0;

    repeat (3) @(negedge clk);
    check("reset/a1", myinA1, 0);
    check("reset/a2", myinA2, 0);
    check("reset/busy", bus.busy, 0);
    check("reset/done", bus.done, 0);
    check("reset/meas", bus.meas_cycles, 0);
    check("reset/timed_out", bus.timed_out, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // tag, dir, delta, settle, resp, meas, timed_out, poke
    run("rise_d0_s3",   1'b1,    0, 3,   5,    7, 1'b0, 1'b1);
    run("rise_dp4",     1'b1,    4, 0,   8,   10, 1'b0, 1'b0);
    run("rise_dm4",     1'b1,   -4, 1,   6,    8, 1'b0, 1'b0);
    run("fall_dm128",   1'b0, -128, 2, 200,  202, 1'b0, 1'b0);
    run("fall_early",   1'b0,   10, 0,   3,    5, 1'b0, 1'b0);
    run("fall_dp1",     1'b0,    1, 0,   4,    6, 1'b0, 1'b0);
    run("timeout",      1'b1,    0, 0,  -1, 1000, 1'b1, 1'b0);

    // Reset during SKEW aborts immediately with no done pulse.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.dir    = 1'b1;
    bus.delta  = DELTA_W'(20);
    bus.settle = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check("abort/to_clr", bus.timed_out, 0);
    n = 0;
    while (myinA1 != 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort/lead_a1", myinA1, 1);
    repeat (3) @(negedge clk);
    check("abort/in_skew_a2", myinA2, 0);
    rst_n = 1'b0;
    n_done = 0;
    @(negedge clk);
    if (bus.done) n_done++;
    check("abort/a1", myinA1, 0);
    check("abort/a2", myinA2, 0);
    check("abort/busy", bus.busy, 0);
    check("abort/meas", bus.meas_cycles, 0);
    check("abort/timed_out", bus.timed_out, 0);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort/no_done", n_done, 0);
    check("abort/idle_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
